// File: rtl/mul_sign_wrap.sv
// Sign-handling, handshaked wrapper around an external 32x32 unsigned multiplier.
// Stage 1 holds operand magnitudes for MUL_CYCLES cycles; stage 2 holds the sign-corrected product.
module mul_sign_wrap #(
    parameter int unsigned MUL_CYCLES = 1  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_op,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_y
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

    logic          s1_valid;
    logic          s2_valid;
    logic          neg;
    logic [CW-1:0] cnt;

    logic sign_a;
    logic sign_b;
    logic s1_done;
    logic xfer;
    logic accept;

    // Handshake decode; in_ready only sees out_ready once stage 1 has settled.
    always_comb begin
        sign_a   = 1'b0;
        sign_b   = 1'b0;
        s1_done  = 1'b0;
        xfer     = 1'b0;
        in_ready = 1'b0;
        accept   = 1'b0;

        sign_a   = ((in_op == 2'b01) || (in_op == 2'b10)) && in_a[DW-1];
        sign_b   = (in_op == 2'b01) && in_b[DW-1];
        s1_done  = s1_valid && (cnt == '0);
        xfer     = s1_done && (!s2_valid || out_ready);
        in_ready = !s1_valid || xfer;
        accept   = in_valid && in_ready;
    end

    // Stage 1: operand magnitudes and settle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            neg      <= 1'b0;
            cnt      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            neg      <= sign_a ^ sign_b;
            cnt      <= CNT_LOAD;
            mul_a    <= sign_a ? (~in_a + DW'(1)) : in_a;
            mul_b    <= sign_b ? (~in_b + DW'(1)) : in_b;
        end else if (xfer) begin
            s1_valid <= 1'b0;
        end else if (s1_valid && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Stage 2: sign-restored product, held under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_y    <= '0;
        end else if (xfer) begin
            s2_valid <= 1'b1;
            out_y    <= neg ? (~mul_y + PW'(1)) : mul_y;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_mul_sign_wrap.sv
// Self-checking bench for mul_sign_wrap: vector table, scoreboard, backpressure,
// mid-operation reset (MUL_CYCLES=1) and streaming throughput (MUL_CYCLES=3).
module tb_mul_sign_wrap;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, mul_a, mul_b;
    logic [1:0]  in_op;
    logic [63:0] mul_y, out_y;

    logic        in_valid3, in_ready3, out_valid3, out_ready3;
    logic [31:0] in_a3, in_b3, mul_a3, mul_b3;
    logic [1:0]  in_op3;
    logic [63:0] mul_y3, out_y3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_out1 = 0;
    int n_out3 = 0;

    logic [63:0] q1[$];
    logic [63:0] q3[$];
    int          acc_t[$];
    int          out_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier models
    assign mul_y  = {32'd0, mul_a}  * {32'd0, mul_b};
    assign mul_y3 = {32'd0, mul_a3} * {32'd0, mul_b3};

    mul_sign_wrap #(.MUL_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .mul_a(mul_a), .mul_b(mul_b),
        .mul_y(mul_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
    );

    mul_sign_wrap #(.MUL_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_op(in_op3), .mul_a(mul_a3), .mul_b(mul_b3),
        .mul_y(mul_y3), .out_valid(out_valid3), .out_ready(out_ready3), .out_y(out_y3)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [63:0] y;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic signed [63:0] xa, xb;
        xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        return 64'(xa * xb);
    endfunction

    // Scoreboard for dut1: pop on output handshake, push on input handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out1++;
                if (q1.size() == 0) chk("sb1_unexpected", 64'(out_valid), 64'd0);
                else                chk("sb1_out", out_y, q1.pop_front());
            end
            if (in_valid && in_ready) q1.push_back(ref_mul(in_a, in_b, in_op));
        end
    end

    // Scoreboard for dut3 with handshake timestamps
    always @(negedge clk) begin
        if (!rst_n) begin
            q3.delete();
        end else begin
            if (out_valid3 && out_ready3) begin
                n_out3++;
                out_t.push_back(cyc);
                if (q3.size() == 0) chk("sb3_unexpected", 64'(out_valid3), 64'd0);
                else                chk("sb3_out", out_y3, q3.pop_front());
            end
            if (in_valid3 && in_ready3) begin
                acc_t.push_back(cyc);
                q3.push_back(ref_mul(in_a3, in_b3, in_op3));
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = v.a; in_b = v.b; in_op = v.op;
        @(negedge clk);
        chk($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d_mul_a", idx), 64'(mul_a), 64'(v.ma));
        chk($sformatf("vec%0d_mul_b", idx), 64'(mul_b), 64'(v.mb));
        chk($sformatf("vec%0d_early_valid", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        chk($sformatf("vec%0d_out_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("vec%0d_out_y", idx), out_y, v.y);
    endtask

    initial begin
        logic [31:0] bp_a[4];
        logic [31:0] bp_b[4];
        logic [1:0]  bp_op[4];
        logic [31:0] s_a[9];
        logic [31:0] s_b[9];
        logic [1:0]  s_op[9];
        int acc;
        int base;
        bit done;

        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFB, 2'b01, 32'h0000_0000, 32'h0000_0005, 64'h0};
        vecs[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0002};
        vecs[6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 64'hFFFF_FFFD_0000_0002};
        vecs[7] = '{32'h0000_0005, 32'hFFFF_FFF9, 2'b01, 32'h0000_0005, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFDD};
        vecs[8] = '{32'h0000_0007, 32'h8000_0001, 2'b10, 32'h0000_0007, 32'h8000_0001, 64'h0000_0003_8000_0007};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; in_op3 = '0; out_ready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_y",     out_y,          64'd0);
        chk("rst_mul_a",     64'(mul_a),     64'd0);
        chk("rst_mul_b",     64'(mul_b),     64'd0);

        // Vector table, one op at a time
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Backpressure: 3 ops offered with out_ready low for 10 cycles
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = $urandom; bp_b[i] = $urandom; bp_op[i] = 2'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc = 0;
        base = n_out1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a = bp_a[acc]; in_b = bp_b[acc]; in_op = bp_op[acc];
            @(negedge clk);
            if (in_valid && in_ready && acc < 3) acc++;
        end
        chk("bp_accepted",  64'(acc),       64'd2);
        chk("bp_in_ready",  64'(in_ready),  64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out_y_held", out_y, ref_mul(bp_a[0], bp_b[0], bp_op[0]));
        @(posedge clk); #1;
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        chk("bp_third_accept", 64'(done), 64'd1);
        in_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (q1.size() == 0 && !out_valid) done = 1'b1;
        end
        chk("bp_drained", 64'(done), 64'd1);
        chk("bp_result_count", 64'(n_out1 - base), 64'd3);

        // Mid-operation reset with both stages occupied
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid = (acc < 2);
            in_a = $urandom; in_b = $urandom; in_op = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0;
        chk("mr_pre_out_valid", 64'(out_valid), 64'd1);
        chk("mr_pre_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_in_ready",  64'(in_ready),  64'd1);
        chk("mr_out_y",     out_y,          64'd0);
        chk("mr_mul_a",     64'(mul_a),     64'd0);
        chk("mr_mul_b",     64'(mul_b),     64'd0);
        base = n_out1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_no_stale", 64'(n_out1 - base), 64'd0);

        // Streaming on MUL_CYCLES=3 with out_ready held high
        for (int i = 0; i < 9; i++) begin
            s_a[i] = $urandom; s_b[i] = $urandom; s_op[i] = 2'($urandom_range(0, 3));
        end
        acc = 0;
        for (int c = 0; c < 80 && !(acc == 8 && n_out3 == 8); c++) begin
            @(posedge clk); #1;
            in_valid3 = (acc < 8);
            in_a3 = s_a[acc]; in_b3 = s_b[acc]; in_op3 = s_op[acc];
            @(negedge clk);
            if (in_valid3 && in_ready3 && acc < 8) acc++;
        end
        in_valid3 = 1'b0;
        chk("st_accepted", 64'(acc),    64'd8);
        chk("st_results",  64'(n_out3), 64'd8);
        if (acc_t.size() == 8 && out_t.size() == 8) begin
            chk("st_latency", 64'(out_t[0] - acc_t[0]), 64'd4);
            for (int i = 1; i < 8; i++) begin
                chk($sformatf("st_acc_gap%0d", i), 64'(acc_t[i] - acc_t[i-1]), 64'd3);
                chk($sformatf("st_out_gap%0d", i), 64'(out_t[i] - out_t[i-1]), 64'd3);
            end
        end else begin
            chk("st_timestamps", 64'(acc_t.size() + out_t.size()), 64'd16);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
